// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets N_REQ requesters burst words
// into one write-side FIFO port. A grant lasts at most BURST_MAX words and is
// cut short when the owner runs dry or the FIFO signals almost-full.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    grant,
  output logic                winc,
  output logic [DW-1:0]       wdata,
  input  logic                wfull,
  input  logic                wfull_almost,
  output logic                busy,
  output logic [15:0]         word_cnt
);

  localparam int              IW        = $clog2(N_REQ);
  localparam logic [3:0]      BEAT_LAST = 4'(BURST_MAX);
  localparam logic [IW-1:0]   LAST_RST  = IW'(N_REQ - 1);
  localparam logic [IW:0]     N_WIDE    = (IW+1)'(N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [IW-1:0]    owner_reg, owner_next;
  logic [IW-1:0]    last_reg, last_next;
  logic [3:0]       beat_reg, beat_next;
  logic [15:0]      word_cnt_reg, word_cnt_next;

  logic [DW-1:0]    word_arr [N_REQ];
  logic [IW-1:0]    cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_hit;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;

  logic             owner_req;
  logic [DW-1:0]    owner_word;
  logic [3:0]       beat_inc;
  logic             winc_c;
  logic [DW-1:0]    wdata_c;

  genvar gi;

  // Split the flat data bus into one word per requester.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign word_arr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // Round-robin candidate list: slot k holds index (last + 1 + k) mod N_REQ.
  // last < N_REQ and the offset is <= N_REQ, so one conditional subtract
  // replaces a general modulo.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rr
      logic [IW:0] sum;
      assign sum          = {1'b0, last_reg} + (IW+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= N_WIDE) ? IW'(sum - N_WIDE) : sum[IW-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // First active requester in round-robin order wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!pick_valid && cand_hit[k]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  assign owner_req  = req[owner_reg];
  assign owner_word = word_arr[owner_reg];
  assign beat_inc   = beat_reg + 4'd1;

  // Write strobe and data: only the burst owner may write, and only when
  // the FIFO has room; everything is forced to zero outside a burst.
  always_comb begin
    winc_c  = 1'b0;
    wdata_c = '0;
    if (state_reg == XFER) begin
      winc_c  = owner_req & ~wfull;
      wdata_c = owner_word;
    end
  end

  // Per-requester acknowledge mirrors the write strobe for the owner only.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ack
      assign ack[gi] = winc_c & (owner_reg == IW'(gi));
    end
  endgenerate

  // Next-state logic: arbitrate in IDLE, count beats and decide burst end in XFER.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    owner_next    = owner_reg;
    last_next     = last_reg;
    beat_next     = beat_reg;
    word_cnt_next = word_cnt_reg + 16'(winc_c);
    case (state_reg)
      IDLE: begin
        if (pick_valid && !wfull) begin
          state_next = XFER;
          grant_next = N_REQ'(1) << pick_idx;
          owner_next = pick_idx;
          beat_next  = '0;
        end
      end
      XFER: begin
        if (winc_c) begin
          beat_next = beat_inc;
        end
        // A stall (wfull with the owner still requesting) falls through and
        // holds everything; any of the end conditions releases the grant.
        if (!owner_req ||
            (winc_c && (beat_inc == BEAT_LAST || wfull_almost))) begin
          state_next = IDLE;
          grant_next = '0;
          last_next  = owner_reg;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // State registers; reset points the round-robin pointer at the last index
  // so the first search after reset starts from requester 0.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      owner_reg    <= '0;
      last_reg     <= LAST_RST;
      beat_reg     <= '0;
      word_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      beat_reg     <= beat_next;
      word_cnt_reg <= word_cnt_next;
    end
  end

  assign grant    = grant_reg;
  assign busy     = (state_reg == XFER);
  assign winc     = winc_c;
  assign wdata    = wdata_c;
  assign word_cnt = word_cnt_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed bursts on a 4-requester instance
// checked through a write scoreboard, plus a 2-requester instance that runs
// word_cnt through its 16-bit wrap.
module tb_fifo_wr_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 8;

  logic                wclk = 1'b0;
  logic                wrst;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    ack;
  logic [N_REQ-1:0]    grant;
  logic                winc;
  logic [DW-1:0]       wdata;
  logic                wfull;
  logic                wfull_almost;
  logic                busy;
  logic [15:0]         word_cnt;

  logic                wrst2;
  logic [1:0]          req2;
  logic [15:0]         req_data2;
  logic [1:0]          ack2;
  logic [1:0]          grant2;
  logic                winc2;
  logic [7:0]          wdata2;
  logic                busy2;
  logic [15:0]         word_cnt2;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.N_REQ(N_REQ), .DW(DW), .BURST_MAX(4)) u_dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .ack(ack),
    .grant(grant), .winc(winc), .wdata(wdata), .wfull(wfull),
    .wfull_almost(wfull_almost), .busy(busy), .word_cnt(word_cnt)
  );

  fifo_wr_arbiter #(.N_REQ(2), .DW(8), .BURST_MAX(15)) u_wrap (
    .wclk(wclk), .wrst(wrst2), .req(req2), .req_data(req_data2), .ack(ack2),
    .grant(grant2), .winc(winc2), .wdata(wdata2), .wfull(1'b0),
    .wfull_almost(1'b0), .busy(busy2), .word_cnt(word_cnt2)
  );

  typedef struct {
    int            src;
    logic [DW-1:0] data;
  } exp_t;

  exp_t             exp_q[$];
  int               remaining [N_REQ];
  int               seq       [N_REQ];
  int               pseq      [N_REQ];
  logic [N_REQ-1:0] ack_s;
  int               n_checks = 0;
  int               n_fail   = 0;
  int               wrap_writes = 0;
  bit               wrap_mid_done = 1'b0;
  bit               wrap_done = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input int i, input int c);
    logic [1:0] ii;
    logic [5:0] cc;
    ii = 2'(i);
    cc = 6'(c);
    return {ii, cc};
  endfunction

  // Requester model outputs: req high while words remain, current word on its slice.
  task automatic drive_req();
    for (int i = 0; i < N_REQ; i++) begin
      req[i] = (remaining[i] > 0);
      req_data[i*DW +: DW] = mkdata(i, seq[i]);
    end
  endtask

  // Advance one clock; requesters move to their next word after an ack.
  task automatic tick();
    @(posedge wclk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (ack_s[i]) begin
        remaining[i]--;
        seq[i]++;
      end
    end
    ack_s = '0;
    drive_req();
  endtask

  // Queue the next n words expected from requester src, in write order.
  task automatic push_words(input int src, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.src  = src;
      e.data = mkdata(src, pseq[src]);
      pseq[src]++;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || req != '0) && n < 200) begin
      tick();
      n++;
    end
    check_val(tag, 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  // Write monitor: samples mid-cycle, pops the scoreboard on every write.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      ack_s = ack;
      if (winc) begin
        if (exp_q.size() == 0) begin
          check_val("write_unexpected", 32'(winc), 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("write: src=%0d ack=%b wdata=0x%02h expected src=%0d data=0x%02h word_cnt=%0d",
                   e.src, ack, wdata, e.src, e.data, word_cnt);
          check_val("wdata", 32'(wdata), 32'(e.data));
          check_val("ack_onehot", 32'(ack), 32'd1 << e.src);
        end
      end else if (!wrst) begin
        check_val("ack_without_winc", 32'(ack), 32'd0);
      end
      if (!wrst && !busy) begin
        check_val("wdata_idle", 32'(wdata), 32'd0);
      end
      if (!wrap_done) begin
        if (wrap_writes == 65534 && !wrap_mid_done) begin
          check_val("wrap_fffe", 32'(word_cnt2), 32'h0000_FFFE);
          wrap_mid_done = 1'b1;
        end
        if (wrap_writes == 65537) begin
          check_val("wrap_0001", 32'(word_cnt2), 32'h0000_0001);
          wrap_done = 1'b1;
          req2 = 2'b00;
        end else if (winc2) begin
          wrap_writes++;
        end
      end
    end
  end

  initial begin
    wrst = 1'b1;
    wrst2 = 1'b1;
    wfull = 1'b0;
    wfull_almost = 1'b0;
    req2 = 2'b00;
    req_data2 = 16'hA55A;
    ack_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      remaining[i] = 0;
      seq[i] = 0;
      pseq[i] = 0;
    end
    drive_req();
    repeat (3) tick();

    // Reset state
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_winc", 32'(winc), 32'd0);
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_word_cnt", 32'(word_cnt), 32'd0);
    wrst = 1'b0;
    wrst2 = 1'b0;
    req2 = 2'b11;
    tick();

    // Single requester: 4-word burst, one idle cycle, re-grant
    remaining[0] = 8;
    push_words(0, 8);
    drive_req();
    tick();
    check_val("t1_grant", 32'(grant), 32'h1);
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_first_winc", 32'(winc), 32'd1);
    repeat (4) tick();
    check_val("t1_idle_gap_grant", 32'(grant), 32'd0);
    check_val("t1_idle_gap_busy", 32'(busy), 32'd0);
    check_val("t1_word_cnt_4", 32'(word_cnt), 32'd4);
    tick();
    check_val("t1_regrant", 32'(grant), 32'h1);
    wait_idle("t1_drain");
    check_val("t1_word_cnt_8", 32'(word_cnt), 32'd8);

    // All four requesting after reset: order 0,1,2,3,0
    wrst = 1'b1;
    repeat (2) tick();
    check_val("t2_rst_word_cnt", 32'(word_cnt), 32'd0);
    wrst = 1'b0;
    remaining[0] = 8;
    remaining[1] = 4;
    remaining[2] = 4;
    remaining[3] = 4;
    push_words(0, 4);
    push_words(1, 4);
    push_words(2, 4);
    push_words(3, 4);
    push_words(0, 4);
    drive_req();
    wait_idle("t2_drain");
    check_val("t2_word_cnt", 32'(word_cnt), 32'd20);

    // Requester 2 alone, FIFO full for 5 cycles after beat 2
    remaining[2] = 4;
    push_words(2, 4);
    drive_req();
    tick();
    check_val("t3_grant", 32'(grant), 32'h4);
    repeat (2) tick();
    wfull = 1'b1;
    #1;
    check_val("t3_stall_winc0", 32'(winc), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("t3_stall_winc", 32'(winc), 32'd0);
      check_val("t3_stall_grant", 32'(grant), 32'h4);
    end
    check_val("t3_stall_word_cnt", 32'(word_cnt), 32'd22);
    wfull = 1'b0;
    wait_idle("t3_drain");
    check_val("t3_word_cnt", 32'(word_cnt), 32'd24);

    // Almost-full on requester 1's first beat ends its burst early
    remaining[1] = 4;
    remaining[2] = 4;
    wfull_almost = 1'b1;
    push_words(1, 1);
    push_words(2, 4);
    push_words(1, 3);
    drive_req();
    tick();
    check_val("t4_grant1", 32'(grant), 32'h2);
    tick();
    wfull_almost = 1'b0;
    check_val("t4_early_exit", 32'(grant), 32'd0);
    check_val("t4_one_word", 32'(word_cnt), 32'd25);
    tick();
    check_val("t4_next_rr", 32'(grant), 32'h4);
    wait_idle("t4_drain");
    check_val("t4_word_cnt", 32'(word_cnt), 32'd32);

    // Reset during beat 3 of requester 3's burst
    remaining[3] = 4;
    push_words(3, 2);
    drive_req();
    tick();
    check_val("t5_grant", 32'(grant), 32'h8);
    repeat (2) tick();
    wrst = 1'b1;
    #1;
    check_val("t5_rst_winc", 32'(winc), 32'd0);
    check_val("t5_rst_ack", 32'(ack), 32'd0);
    check_val("t5_rst_grant", 32'(grant), 32'd0);
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_word_cnt", 32'(word_cnt), 32'd0);
    remaining[0] = 2;
    push_words(0, 2);
    push_words(3, 2);
    repeat (2) tick();
    wrst = 1'b0;
    tick();
    check_val("t5_post_rst_grant", 32'(grant), 32'h1);
    wait_idle("t5_drain");
    check_val("t5_word_cnt", 32'(word_cnt), 32'd4);

    // word_cnt wrap on the second instance
    for (int n = 0; n < 80000 && !wrap_done; n++) tick();
    check_val("wrap_writes", 32'(wrap_writes), 32'd65537);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of write requesters (2..8).
REQ-002 Parameter DW, default 8, SHALL set the data width of each word (matches the FIFO data width).
REQ-003 Parameter BURST_MAX, default 4, SHALL set the maximum words per grant (1..15).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset: ports wclk and wrst.
REQ-005 wclk  in  1  write-domain clock; all state updates on rising edge.
REQ-006 wrst  in  1  asynchronous active-high reset.
REQ-007 req  in  N_REQ  per-requester "word available" level, bit i = requester i.
REQ-008 req_data  in  N_REQ*DW  requester i's word on bits [i*DW +: DW].
REQ-009 ack  out  N_REQ  one-hot pulse: requester i's word was written this cycle.
REQ-010 grant  out  N_REQ  one-hot (or zero) registered: current burst owner.
REQ-011 winc  out  1  FIFO write enable.
REQ-012 wdata  out  DW  FIFO write data.
REQ-013 wfull  in  1  FIFO full flag.
REQ-014 wfull_almost  in  1  FIFO almost-full flag.
REQ-015 busy  out  1  high while the state is XFER.
REQ-016 word_cnt  out  16  total words written since reset, wraps 0xFFFF->0.

Function
REQ-017 FSM SHALL have two states: IDLE and XFER.
REQ-018 IDLE: if any req bit is high and wfull is low, the arbiter SHALL pick the winner round-robin, searching from (last+1) mod N_REQ upward, register grant = winner, clear beat count, and go to XFER; otherwise it SHALL stay in IDLE.
REQ-019 XFER: winc SHALL be combinational = req[owner] & ~wfull; wdata SHALL be req_data slice of owner; ack[owner] SHALL equal winc; all other ack bits SHALL be 0.
REQ-020 In IDLE, winc, ack and wdata SHALL be 0.
REQ-021 The beat counter (4 bits) SHALL increment on each winc in XFER.
REQ-022 XFER SHALL exit to IDLE at the next edge when any of these holds:
- req[owner] is low;
- winc is high and the beat count reaches BURST_MAX with this word;
- winc is high and wfull_almost is high (early burst termination).
REQ-023 While wfull is high in XFER with req[owner] high, the block SHALL hold state, grant and beat count, with winc low (stall, no timeout).
REQ-024 On XFER exit, last SHALL be loaded with the owner index, and grant SHALL be cleared.
REQ-025 At least one IDLE cycle SHALL separate consecutive bursts; each new grant is re-arbitrated.
REQ-026 Latency: with the FIFO not full, req rising in IDLE SHALL give grant and the first winc/ack one cycle later.
REQ-027 Requesters SHALL present the next word in the cycle after ack; req low with ack means no more words.
REQ-028 word_cnt SHALL increment by 1 on every winc, with modulo-2^16 wrap.
REQ-029 Simultaneous wfull rising and req[owner] falling: exit per REQ-022 with no write.

Reset
REQ-030 While wrst is high, the block SHALL hold: state=IDLE, grant=0, beat=0, last=N_REQ-1, word_cnt=0, busy=0, winc=0, ack=0.
REQ-031 Reset asserted mid-burst SHALL abort immediately with no further winc; after release, the first grant SHALL go to the lowest-index active requester.

Verification
REQ-032 Reset, then req=4'b0001 held, FIFO empty -> grant=0001 at cycle 1; winc/ack for 4 cycles; IDLE 1 cycle; re-grant to requester 0; word_cnt=4 after the first burst.
REQ-033 req=4'b1111 held -> grants in order 0,1,2,3,0, each burst 4 words.
REQ-034 Requester 2 alone; wfull=1 for 5 cycles after beat 2 -> winc low for 5 cycles, grant held, burst completes with 4 words total.
REQ-035 wfull_almost=1 during beat 1 of requester 1 -> burst ends after 1 word; next grant goes to requester 2 if active.
REQ-036 Assert wrst at beat 3 of a burst -> winc drops the same cycle; word_cnt=0; last=N_REQ-1.
REQ-037 Preload word_cnt to 0xFFFE via writes, then 3 more writes -> word_cnt=0x0001.
